game_ctrl: RTL and testbench

Parametrised game-state sequencer for the VGA runner games. Owns the start/over/run lifecycle, restart hold-off, multi-life handling with post-hit invulnerability, per-lane obstacle type latching and high-score capture. Sits between the input pins and the jumping/scroll/score/rendering units: it drives their halt and reset and consumes collision, obstacle-select and rng bits.

---
 rtl/game_ctrl_if.sv | 42 ++++
 rtl/game_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// game_ctrl signal bundle: player pins, rendering/score feedback and the
// control outputs that go back to the game units. The "slave" side is the
// sequencer itself and the "master" side is everything around it.
interface game_ctrl_if #(
  parameter int N_OBS   = 3,
  parameter int TYPE_W  = 1,
  parameter int LIVES   = 1,
  parameter int SCORE_W = 16
);
  localparam int LIVES_W = $clog2(LIVES + 1);

  // player / environment inputs
  logic                      jump_in;
  logic                      halt_in;
  logic                      debug_in;
  logic                      collision;
  logic [N_OBS-1:0]          obstacle_select;
  logic [N_OBS*TYPE_W-1:0]   random;
  logic [SCORE_W-1:0]        score_in;

  // sequencer outputs
  logic                      game_reset;
  logic                      game_halt;
  logic                      game_over;
  logic                      start_blink;
  logic [N_OBS*TYPE_W-1:0]   obstacle_type;
  logic [LIVES_W-1:0]        lives;
  logic [SCORE_W-1:0]        high_score;
  logic [1:0]                state;

  modport master (
    output jump_in, halt_in, debug_in, collision, obstacle_select, random, score_in,
    input  game_reset, game_halt, game_over, start_blink, obstacle_type, lives,
           high_score, state
  );

  modport slave (
    input  jump_in, halt_in, debug_in, collision, obstacle_select, random, score_in,
    output game_reset, game_halt, game_over, start_blink, obstacle_type, lives,
           high_score, state
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: lifecycle sequencer for the VGA runner games.
// OVER -> (jump after hold-off) -> START (fixed countdown) -> RUN.
// A hit in RUN either costs a life and enters a timed INVULN window, or on the
// final life ends the game and captures the high score. Obstacle lane types
// are latched from the rng on each rising lane-select strobe in every state.
module game_ctrl #(
  parameter int START_TIME  = 30000000,
  parameter int HOLDOFF     = 100000,
  parameter int N_OBS       = 3,
  parameter int TYPE_W      = 1,
  parameter int LIVES       = 1,
  parameter int INVULN_TIME = 10000000,
  parameter int SCORE_W     = 16,
  parameter int BLINK_BIT   = 22
) (
  input  logic        clk,
  input  logic        sys_rst,
  game_ctrl_if.slave  bus
);

  localparam int START_W = $clog2(START_TIME + 1);
  localparam int HOLD_W  = $clog2(HOLDOFF + 1);
  localparam int INV_W   = $clog2(INVULN_TIME + 1);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int OBS_W   = N_OBS * TYPE_W;

  typedef enum logic [1:0] {
    ST_OVER   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_INVULN = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [HOLD_W-1:0]    holdoff_ctr_r;
  logic [START_W-1:0]   start_ctr_r;
  logic [INV_W-1:0]     inv_ctr_r;
  logic [LIVES_W-1:0]   lives_r;
  logic [SCORE_W-1:0]   high_score_r;
  logic [OBS_W-1:0]     obs_type_r;
  logic [OBS_W-1:0]     obs_type_nxt_s;
  logic [N_OBS-1:0]     sel_last_r;

  logic                 game_reset_s;
  logic                 game_halt_s;
  logic                 game_over_s;
  logic                 start_blink_s;
  logic                 hit_s;
  logic                 last_life_s;
  logic                 start_done_s;
  logic                 inv_done_s;
  logic [N_OBS-1:0]     obs_load_s;

  // Decode the qualifying events the FSM and counters react to.
  always_comb begin
    // Restart needs a long-enough release before the accepting press; that
    // press clears holdoff_ctr, so the pulse cannot last more than one cycle.
    game_reset_s = (state_r == ST_OVER) && bus.jump_in &&
                   (holdoff_ctr_r >= HOLD_W'(HOLDOFF));
    hit_s        = bus.collision & ~bus.debug_in & ~bus.halt_in;
    last_life_s  = (lives_r == LIVES_W'(1));
    start_done_s = (start_ctr_r == START_W'(START_TIME - 1));
    inv_done_s   = (inv_ctr_r == INV_W'(INVULN_TIME - 1)) && !bus.halt_in;
    obs_load_s   = bus.obstacle_select & ~sel_last_r;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r <= ST_OVER;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_OVER: begin
        if (game_reset_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      ST_START: begin
        if (start_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_RUN: begin
        if (hit_s && last_life_s) begin
          state_nxt_s = ST_OVER;
        end else if (hit_s) begin
          state_nxt_s = ST_INVULN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_INVULN: begin
        if (inv_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INVULN;
        end
      end
      default: begin
        state_nxt_s = ST_OVER;
      end
    endcase
  end

  // FSM outputs, decoded straight from registered state and start counter.
  always_comb begin
    game_halt_s   = 1'b0;
    game_over_s   = 1'b0;
    start_blink_s = 1'b1;
    case (state_r)
      ST_OVER: begin
        game_halt_s   = 1'b1;
        game_over_s   = 1'b1;
        start_blink_s = 1'b1;
      end
      ST_START: begin
        game_halt_s   = 1'b1;
        game_over_s   = 1'b0;
        start_blink_s = start_ctr_r[BLINK_BIT];
      end
      ST_RUN, ST_INVULN: begin
        game_halt_s   = bus.halt_in;
        game_over_s   = 1'b0;
        start_blink_s = 1'b1;
      end
      default: begin
        game_halt_s   = 1'b1;
        game_over_s   = 1'b1;
        start_blink_s = 1'b1;
      end
    endcase
  end

  // Restart hold-off: counts jump-released cycles, saturating at HOLDOFF.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      holdoff_ctr_r <= '0;
    end else if (bus.jump_in) begin
      holdoff_ctr_r <= '0;
    end else if (holdoff_ctr_r < HOLD_W'(HOLDOFF)) begin
      holdoff_ctr_r <= holdoff_ctr_r + HOLD_W'(1);
    end else begin
      holdoff_ctr_r <= holdoff_ctr_r;
    end
  end

  // START countdown: runs every START cycle regardless of halt_in, so the
  // countdown length is fixed; it ends at START_TIME and then holds.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      start_ctr_r <= '0;
    end else if (game_reset_s) begin
      start_ctr_r <= '0;
    end else if (state_r == ST_START) begin
      start_ctr_r <= start_ctr_r + START_W'(1);
    end else begin
      start_ctr_r <= start_ctr_r;
    end
  end

  // Invulnerability timer: armed by a non-final hit, frozen while paused.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      inv_ctr_r <= '0;
    end else if ((state_r == ST_RUN) && hit_s && !last_life_s) begin
      inv_ctr_r <= '0;
    end else if ((state_r == ST_INVULN) && !bus.halt_in) begin
      inv_ctr_r <= inv_ctr_r + INV_W'(1);
    end else begin
      inv_ctr_r <= inv_ctr_r;
    end
  end

  // Lives: refilled on restart, one lost per accepted hit (final hit -> 0).
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      lives_r <= LIVES_W'(LIVES);
    end else if (game_reset_s) begin
      lives_r <= LIVES_W'(LIVES);
    end else if ((state_r == ST_RUN) && hit_s) begin
      lives_r <= lives_r - LIVES_W'(1);
    end else begin
      lives_r <= lives_r;
    end
  end

  // High score: sampled from score_in on the cycle of the game-ending hit.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      high_score_r <= '0;
    end else if ((state_r == ST_RUN) && hit_s && last_life_s &&
                 (bus.score_in > high_score_r)) begin
      high_score_r <= bus.score_in;
    end else begin
      high_score_r <= high_score_r;
    end
  end

  // Per-lane type selection: a lane reloads only on its select rising edge.
  always_comb begin
    obs_type_nxt_s = obs_type_r;
    for (int i = 0; i < N_OBS; i++) begin
      if (obs_load_s[i]) begin
        obs_type_nxt_s[i*TYPE_W +: TYPE_W] = bus.random[i*TYPE_W +: TYPE_W];
      end else begin
        obs_type_nxt_s[i*TYPE_W +: TYPE_W] = obs_type_r[i*TYPE_W +: TYPE_W];
      end
    end
  end

  // Obstacle type and select-history registers.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      obs_type_r <= '0;
      sel_last_r <= '0;
    end else begin
      obs_type_r <= obs_type_nxt_s;
      sel_last_r <= bus.obstacle_select;
    end
  end

  assign bus.game_reset    = game_reset_s;
  assign bus.game_halt     = game_halt_s;
  assign bus.game_over     = game_over_s;
  assign bus.start_blink   = start_blink_s;
  assign bus.obstacle_type = obs_type_r;
  assign bus.lives         = lives_r;
  assign bus.high_score    = high_score_r;
  assign bus.state         = state_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl with small timing parameters.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_game_ctrl;

  localparam int START_TIME  = 8;
  localparam int HOLDOFF     = 4;
  localparam int N_OBS       = 3;
  localparam int TYPE_W      = 1;
  localparam int LIVES       = 2;
  localparam int INVULN_TIME = 5;
  localparam int SCORE_W     = 16;
  localparam int BLINK_BIT   = 1;

  logic clk = 1'b0;
  logic sys_rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  game_ctrl_if #(.N_OBS(N_OBS), .TYPE_W(TYPE_W), .LIVES(LIVES), .SCORE_W(SCORE_W)) bus ();

  game_ctrl #(
    .START_TIME(START_TIME), .HOLDOFF(HOLDOFF), .N_OBS(N_OBS), .TYPE_W(TYPE_W),
    .LIVES(LIVES), .INVULN_TIME(INVULN_TIME), .SCORE_W(SCORE_W), .BLINK_BIT(BLINK_BIT)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    bus.jump_in = 1'b0; bus.halt_in = 1'b0; bus.debug_in = 1'b0; bus.collision = 1'b0;
    bus.obstacle_select = 3'b000; bus.random = 3'b000; bus.score_in = 16'h0000;
    cyc();
    sys_rst = 1'b0;
    #1;
    n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_vec++; if (bus.lives !== 2'd2) begin n_err++; $display("FAIL rst_lives: got %0d want 2", bus.lives); end
    n_vec++; if (bus.high_score !== 16'h0000) begin n_err++; $display("FAIL rst_high: got %h want 0000", bus.high_score); end
    n_vec++; if (bus.obstacle_type !== 3'b000) begin n_err++; $display("FAIL rst_obs: got %b want 000", bus.obstacle_type); end
    n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL rst_over: got %b want 1", bus.game_over); end
    n_vec++; if (bus.game_halt !== 1'b1) begin n_err++; $display("FAIL rst_halt: got %b want 1", bus.game_halt); end
    n_vec++; if (bus.start_blink !== 1'b1) begin n_err++; $display("FAIL rst_blink: got %b want 1", bus.start_blink); end
    n_vec++; if (bus.game_reset !== 1'b0) begin n_err++; $display("FAIL rst_greset: got %b want 0", bus.game_reset); end
  endtask

  task automatic test_holdoff();
    for (int i = 0; i < 10; i++) begin
      bus.jump_in = 1'b1;
      #1;
      n_vec++; if (bus.game_reset !== 1'b0) begin n_err++; $display("FAIL hold_greset[%0d]: got %b want 0", i, bus.game_reset); end
      n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL hold_state[%0d]: got %0d want 0", i, bus.state); end
      n_vec++; if (bus.game_halt !== 1'b1) begin n_err++; $display("FAIL hold_halt[%0d]: got %b want 1", i, bus.game_halt); end
      cyc();
    end
  endtask

  task automatic test_start();
    logic exp_blink;
    for (int i = 0; i < HOLDOFF; i++) begin
      bus.jump_in = 1'b0;
      #1;
      n_vec++; if (bus.game_reset !== 1'b0) begin n_err++; $display("FAIL early_greset[%0d]: got %b want 0", i, bus.game_reset); end
      cyc();
    end
    bus.jump_in = 1'b1;
    #1;
    n_vec++; if (bus.game_reset !== 1'b1) begin n_err++; $display("FAIL accept_greset: got %b want 1", bus.game_reset); end
    cyc();
    #1;
    n_vec++; if (bus.game_reset !== 1'b0) begin n_err++; $display("FAIL oneshot_greset: got %b want 0", bus.game_reset); end
    for (int i = 0; i < START_TIME; i++) begin
      bus.jump_in = 1'b0;
      exp_blink = ((i >> 1) & 1) != 0;
      #1;
      n_vec++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL start_state[%0d]: got %0d want 1", i, bus.state); end
      n_vec++; if (bus.start_blink !== exp_blink) begin n_err++; $display("FAIL start_blink[%0d]: got %b want %b", i, bus.start_blink, exp_blink); end
      n_vec++; if (bus.game_halt !== 1'b1) begin n_err++; $display("FAIL start_halt[%0d]: got %b want 1", i, bus.game_halt); end
      cyc();
    end
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL run_state: got %0d want 2", bus.state); end
    n_vec++; if (bus.game_halt !== 1'b0) begin n_err++; $display("FAIL run_halt: got %b want 0", bus.game_halt); end
    n_vec++; if (bus.start_blink !== 1'b1) begin n_err++; $display("FAIL run_blink: got %b want 1", bus.start_blink); end
  endtask

  task automatic test_invuln();
    bus.collision = 1'b1;
    cyc();
    for (int i = 0; i < INVULN_TIME; i++) begin
      bus.collision = (i == 1);
      #1;
      n_vec++; if (bus.state !== 2'd3) begin n_err++; $display("FAIL inv_state[%0d]: got %0d want 3", i, bus.state); end
      n_vec++; if (bus.lives !== 2'd1) begin n_err++; $display("FAIL inv_lives[%0d]: got %0d want 1", i, bus.lives); end
      cyc();
    end
    bus.collision = 1'b0;
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL inv_exit: got %0d want 2", bus.state); end
    n_vec++; if (bus.lives !== 2'd1) begin n_err++; $display("FAIL inv_exit_lives: got %0d want 1", bus.lives); end
  endtask

  task automatic test_masked_hit();
    bus.debug_in = 1'b1; bus.collision = 1'b1;
    cyc();
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL dbg_state: got %0d want 2", bus.state); end
    n_vec++; if (bus.lives !== 2'd1) begin n_err++; $display("FAIL dbg_lives: got %0d want 1", bus.lives); end
    bus.debug_in = 1'b0; bus.halt_in = 1'b1;
    #1;
    n_vec++; if (bus.game_halt !== 1'b1) begin n_err++; $display("FAIL pause_halt: got %b want 1", bus.game_halt); end
    cyc();
    bus.halt_in = 1'b0; bus.collision = 1'b0;
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL pause_state: got %0d want 2", bus.state); end
    n_vec++; if (bus.lives !== 2'd1) begin n_err++; $display("FAIL pause_lives: got %0d want 1", bus.lives); end
  endtask

  task automatic test_final_hit(input logic [15:0] score, input logic [15:0] exp_high);
    bus.score_in = score; bus.collision = 1'b1;
    cyc();
    bus.collision = 1'b0;
    #1;
    n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL end_state: got %0d want 0", bus.state); end
    n_vec++; if (bus.lives !== 2'd0) begin n_err++; $display("FAIL end_lives: got %0d want 0", bus.lives); end
    n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL end_over: got %b want 1", bus.game_over); end
    n_vec++; if (bus.high_score !== exp_high) begin n_err++; $display("FAIL end_high: got %h want %h", bus.high_score, exp_high); end
  endtask

  task automatic start_game();
    bus.jump_in = 1'b0;
    for (int i = 0; i < HOLDOFF; i++) cyc();
    bus.jump_in = 1'b1;
    cyc();
    bus.jump_in = 1'b0;
    for (int i = 0; i < START_TIME; i++) cyc();
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL restart_state: got %0d want 2", bus.state); end
    n_vec++; if (bus.lives !== 2'd2) begin n_err++; $display("FAIL restart_lives: got %0d want 2", bus.lives); end
  endtask

  task automatic test_invuln_halt();
    logic exp_halt;
    bus.collision = 1'b1;
    cyc();
    bus.collision = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_halt = (i >= 1) && (i <= 3);
      bus.halt_in = exp_halt;
      #1;
      n_vec++; if (bus.state !== 2'd3) begin n_err++; $display("FAIL invh_state[%0d]: got %0d want 3", i, bus.state); end
      n_vec++; if (bus.game_halt !== exp_halt) begin n_err++; $display("FAIL invh_halt[%0d]: got %b want %b", i, bus.game_halt, exp_halt); end
      cyc();
    end
    bus.halt_in = 1'b0;
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL invh_exit: got %0d want 2", bus.state); end
    n_vec++; if (bus.lives !== 2'd1) begin n_err++; $display("FAIL invh_lives: got %0d want 1", bus.lives); end
  endtask

  task automatic test_obstacles();
    bus.obstacle_select = 3'b000; bus.random = 3'b000;
    cyc();
    bus.obstacle_select = 3'b101; bus.random = 3'b110;
    cyc();
    #1;
    n_vec++; if (bus.obstacle_type !== 3'b100) begin n_err++; $display("FAIL obs_rise: got %b want 100", bus.obstacle_type); end
    bus.random = 3'b011;
    cyc();
    #1;
    n_vec++; if (bus.obstacle_type !== 3'b100) begin n_err++; $display("FAIL obs_held: got %b want 100", bus.obstacle_type); end
    bus.obstacle_select = 3'b010; bus.random = 3'b010;
    cyc();
    #1;
    n_vec++; if (bus.obstacle_type !== 3'b110) begin n_err++; $display("FAIL obs_lane1: got %b want 110", bus.obstacle_type); end
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL obs_state: got %0d want 2", bus.state); end
    bus.obstacle_select = 3'b000;
    cyc();
  endtask

  task automatic test_reset_mid_run();
    bus.obstacle_select = 3'b001; bus.random = 3'b001;
    cyc();
    bus.obstacle_select = 3'b000; bus.collision = 1'b1;
    cyc();
    bus.collision = 1'b0;
    for (int i = 0; i < INVULN_TIME; i++) cyc();
    #1;
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL pre_rst_state: got %0d want 2", bus.state); end
    n_vec++; if (bus.obstacle_type !== 3'b111) begin n_err++; $display("FAIL pre_rst_obs: got %b want 111", bus.obstacle_type); end
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0; bus.jump_in = 1'b1;
    #1;
    n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL mid_rst_state: got %0d want 0", bus.state); end
    n_vec++; if (bus.lives !== 2'd2) begin n_err++; $display("FAIL mid_rst_lives: got %0d want 2", bus.lives); end
    n_vec++; if (bus.high_score !== 16'h0000) begin n_err++; $display("FAIL mid_rst_high: got %h want 0000", bus.high_score); end
    n_vec++; if (bus.obstacle_type !== 3'b000) begin n_err++; $display("FAIL mid_rst_obs: got %b want 000", bus.obstacle_type); end
    n_vec++; if (bus.game_reset !== 1'b0) begin n_err++; $display("FAIL mid_rst_greset: got %b want 0", bus.game_reset); end
    cyc();
    bus.jump_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_holdoff();
    test_start();
    test_invuln();
    test_masked_hit();
    test_final_hit(16'h0123, 16'h0123);
    start_game();
    test_invuln_halt();
    test_obstacles();
    test_final_hit(16'h0100, 16'h0123);
    start_game();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
